axi_ram_slave: RTL and testbench

AXI4 responder that terminates the memory-side master port of the bus arbiter and serves icache (single-beat) and dcache (burst) traffic from an on-chip word array. It handles one outstanding transaction at a time. Supported bursts are FIXED, INCR and WRAP, with byte-strobed writes and OKAY/SLVERR/DECERR responses. It replaces the behavioural RAM model as the synthesizable memory endpoint.

---
 rtl/axi_pkg.sv | 16 +
 rtl/axi_if.sv | 48 ++++
 rtl/axi_burst_addr.sv | 37 +++
 rtl/axi_ram_slave.sv | 211 +++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 types for the on-chip RAM responder: burst/response encodings,
// responder FSM states and the response-merging helper.
package axi_pkg;

   typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_t;

   typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;

   typedef enum logic [1:0] {IDLE = 2'd0, RDATA = 2'd1, WDATA = 2'd2, WRESP = 2'd3} state_t;

   // Encodings are ordered by severity, so the numerically larger code wins.
   function automatic resp_t worst_resp(input resp_t a, input resp_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle (no IDs, one outstanding transaction) between the arbiter
// memory port and the RAM responder.
interface axi_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport slave (
      input  araddr, arlen, arsize, arburst, arvalid, rready,
      input  awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      output arready, rdata, rresp, rlast, rvalid,
      output awready, wready, bresp, bvalid
   );

   modport master (
      output araddr, arlen, arsize, arburst, arvalid, rready,
      output awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      input  arready, rdata, rresp, rlast, rvalid,
      input  awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axi_burst_addr.sv
// Combinational AXI burst address step (FIXED/INCR/WRAP) plus legality check
// of the burst shape; shared by the read and write paths of axi_ram_slave.
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic [ADDR_W-1:0] cur,
   input  logic [2:0]        size,
   input  logic [7:0]        len,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next,
   output logic              illegal
);
   localparam int LANE_LOG2 = $clog2(DATA_W / 8);

   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] wrap_mask;
   logic [ADDR_W-1:0] step;
   logic              wrap_len_ok;

   always_comb begin
      incr      = ADDR_W'(1) << size;
      // The wrap window is (len+1) transfers; only power-of-two lengths are legal.
      wrap_mask = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
      step      = cur + incr;
      case (burst_t'(burst))
         INCR:    next = step;
         WRAP:    next = (cur & ~wrap_mask) | (step & wrap_mask);
         default: next = cur;
      endcase
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      illegal     = (int'(size) > LANE_LOG2) || (burst == 2'b11) ||
                    ((burst == 2'b10) && !wrap_len_ok);
   end
endmodule

// File: rtl/axi_ram_slave.sv
// Synthesizable AXI4 RAM responder, one outstanding transaction at a time.
// Define AXI_RAM_STALL_EN to add LFSR-driven backpressure on rvalid/wready/bvalid.
module axi_ram_slave
   import axi_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                MEM_DEPTH = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter string             INIT_FILE = ""
) (
   input logic   clk,
   input logic   rst_n,
   axi_if.slave  s
);
   localparam int STRB_W    = DATA_W / 8;
   localparam int LANE_LOG2 = $clog2(STRB_W);
   localparam int IDX_W     = $clog2(MEM_DEPTH);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cur_q;
   logic [7:0]        len_q, beat_q;
   logic [2:0]        size_q;
   logic [1:0]        burst_q;
   logic              err_q;
   resp_t             bacc_q, bresp_q, rresp_q;
   logic [DATA_W-1:0] rdata_q;
   logic              rlast_q, rvalid_q, bvalid_q;
   logic              stall;

   logic [ADDR_W-1:0] ag_cur, ag_next, rd_addr;
   logic [2:0]        ag_size;
   logic [7:0]        ag_len;
   logic [1:0]        ag_burst;
   logic              ag_illegal, rd_err, rd_dec;
   logic [DATA_W-1:0] rd_word;
   resp_t             rd_resp, w_resp;
   logic              r_hs, w_hs, w_last_exp, w_mis, w_dec, w_en;

   function automatic logic is_decerr(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return (a < BASE_ADDR) || ((off >> LANE_LOG2) >= ADDR_W'(MEM_DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> LANE_LOG2);
   endfunction

`ifdef AXI_RAM_STALL_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= 16'hACE1;
      else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // In IDLE the address unit vets the incoming request; afterwards it steps the burst.
   always_comb begin
      if (state == IDLE) begin
         ag_cur   = s.arvalid ? s.araddr  : s.awaddr;
         ag_size  = s.arvalid ? s.arsize  : s.awsize;
         ag_len   = s.arvalid ? s.arlen   : s.awlen;
         ag_burst = s.arvalid ? s.arburst : s.awburst;
      end else begin
         ag_cur   = cur_q;
         ag_size  = size_q;
         ag_len   = len_q;
         ag_burst = burst_q;
      end
   end

   axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_addr (
      .cur     (ag_cur),
      .size    (ag_size),
      .len     (ag_len),
      .burst   (ag_burst),
      .next    (ag_next),
      .illegal (ag_illegal)
   );

   always_comb begin
      rd_addr = (state == IDLE) ? s.araddr : ag_next;
      rd_err  = (state == IDLE) ? ag_illegal : err_q;
      rd_dec  = is_decerr(rd_addr);
      rd_word = '0;
      rd_resp = OKAY;
      if (rd_err)      rd_resp = SLVERR;
      else if (rd_dec) rd_resp = DECERR;
      else             rd_word = mem[word_idx(rd_addr)];
   end

   always_comb begin
      r_hs       = s.rvalid && s.rready;
      w_hs       = s.wvalid && s.wready;
      w_last_exp = (beat_q == len_q);
      w_mis      = (s.wlast != w_last_exp);
      w_dec      = is_decerr(cur_q);
      w_resp     = OKAY;
      if (err_q || w_mis) w_resp = SLVERR;
      else if (w_dec)     w_resp = DECERR;
      w_en       = w_hs && (w_resp == OKAY);
   end

   always_ff @(posedge clk) begin
      if (w_en)
         for (int b = 0; b < STRB_W; b++)
            if (s.wstrb[b]) mem[word_idx(cur_q)][8*b +: 8] <= s.wdata[8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (s.arvalid)      state_nxt = RDATA;
                  else if (s.awvalid) state_nxt = WDATA;
         RDATA:   if (r_hs && rlast_q)    state_nxt = IDLE;
         WDATA:   if (w_hs && w_last_exp) state_nxt = WRESP;
         WRESP:   if (s.bvalid && s.bready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready outputs are gated by rst_n so they read 0 while reset is held.
   always_comb begin
      s.arready = rst_n && (state == IDLE);
      s.awready = rst_n && (state == IDLE) && !s.arvalid;
      s.wready  = rst_n && (state == WDATA) && !stall;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= OKAY;
         bvalid_q <= 1'b0;
         bresp_q  <= OKAY;
         bacc_q   <= OKAY;
         beat_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               beat_q <= '0;
               err_q  <= ag_illegal;
               bacc_q <= OKAY;
               if (s.arvalid) begin
                  {cur_q, len_q, size_q, burst_q} <= {s.araddr, s.arlen, s.arsize, s.arburst};
                  rdata_q  <= rd_word;
                  rresp_q  <= rd_resp;
                  rlast_q  <= (s.arlen == 8'd0);
                  rvalid_q <= !stall;
               end else if (s.awvalid) begin
                  {cur_q, len_q, size_q, burst_q} <= {s.awaddr, s.awlen, s.awsize, s.awburst};
               end
            end
            RDATA: begin
               if (r_hs) begin
                  if (rlast_q) begin
                     rvalid_q <= 1'b0;
                     rlast_q  <= 1'b0;
                  end else begin
                     cur_q    <= ag_next;
                     beat_q   <= beat_q + 8'd1;
                     rdata_q  <= rd_word;
                     rresp_q  <= rd_resp;
                     rlast_q  <= ((beat_q + 8'd1) == len_q);
                     rvalid_q <= !stall;
                  end
               end else if (!rvalid_q && !stall) begin
                  rvalid_q <= 1'b1;
               end
            end
            WDATA: begin
               if (w_hs) begin
                  cur_q  <= ag_next;
                  beat_q <= beat_q + 8'd1;
                  bacc_q <= worst_resp(bacc_q, w_resp);
                  if (w_mis) err_q <= 1'b1;
                  if (w_last_exp) begin
                     bresp_q  <= worst_resp(bacc_q, w_resp);
                     bvalid_q <= !stall;
                  end
               end
            end
            WRESP: begin
               if (s.bvalid && s.bready)   bvalid_q <= 1'b0;
               else if (!bvalid_q && !stall) bvalid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign s.rdata  = rdata_q;
   assign s.rresp  = rresp_q;
   assign s.rlast  = rlast_q;
   assign s.rvalid = rvalid_q;
   assign s.bresp  = bresp_q;
   assign s.bvalid = bvalid_q;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: tasks drive AXI traffic and queue expected
// R/B responses; a negedge monitor pops and compares every handshake.
module tb_axi_ram_slave;
   import axi_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_if #(.ADDR_W(32), .DATA_W(32)) s ();

   axi_ram_slave #(
      .DATA_W    (32),
      .ADDR_W    (32),
      .MEM_DEPTH (4096),
      .BASE_ADDR (32'h0),
      .INIT_FILE ("")
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (s)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   rbeat_t     rq[$];
   logic [1:0] bq[$];
   rbeat_t     m_r;
   logic [1:0] m_b;
   int         n_vec = 0;
   int         n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && s.rvalid && s.rready) begin
         if (rq.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL r_unexpected: got beat %h expected none", s.rdata);
         end else begin
            m_r = rq.pop_front();
            chk("rdata", s.rdata, m_r.data);
            chk("rresp", 32'(s.rresp), 32'(m_r.resp));
            chk("rlast", 32'(s.rlast), 32'(m_r.last));
         end
      end
      if (rst_n && s.bvalid && s.bready) begin
         if (bq.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL b_unexpected: got bresp %0d expected none", s.bresp);
         end else begin
            m_b = bq.pop_front();
            chk("bresp", 32'(s.bresp), 32'(m_b));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
      rbeat_t e;
      e.data = d; e.resp = r; e.last = l;
      rq.push_back(e);
   endtask

   task automatic aw_hs(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst);
      int t = 0;
      s.awaddr = a; s.awlen = len; s.awsize = size; s.awburst = burst; s.awvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!s.awready && t < 50);
      chk("awready", 32'(s.awready), 32'd1);
      tick();
      s.awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
      int t = 0;
      s.wdata = d; s.wstrb = strb; s.wlast = last; s.wvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!s.wready && t < 50);
      chk("wready", 32'(s.wready), 32'd1);
      tick();
      s.wvalid = 1'b0; s.wlast = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] strb,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3, input logic [1:0] exp_b);
      logic [31:0] d [4];
      int t = 0;
      d = '{d0, d1, d2, d3};
      bq.push_back(exp_b);
      aw_hs(a, len, size, burst);
      for (int i = 0; i <= int'(len); i++) w_beat(d[i % 4], strb, i == int'(len));
      @(negedge clk);
      chk("bvalid_latency", 32'(s.bvalid), 32'd1);
      while (!s.bvalid && t < 50) begin @(negedge clk); t++; end
      tick();
   endtask

   // stall_at: beat index before which rready is held low for 3 cycles (-1 = never).
   task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_at, input logic [31:0] hold_exp);
      int t = 0;
      int beat = 0;
      int hold = 0;
      s.rready = (stall_at != 0);
      s.araddr = a; s.arlen = len; s.arsize = size; s.arburst = burst; s.arvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!s.arready && t < 50);
      chk("arready", 32'(s.arready), 32'd1);
      tick();
      s.arvalid = 1'b0;
      @(negedge clk);
      chk("rvalid_latency", 32'(s.rvalid), 32'd1);
      t = 0;
      while (1) begin
         if (s.rvalid && s.rready) beat++;
         else if (s.rvalid) begin
            chk("rdata_hold", s.rdata, hold_exp);
            hold++;
         end
         if (beat > int'(len) || t >= 100) break;
         tick();
         s.rready = !(beat == stall_at && hold < 3);
         @(negedge clk);
         t++;
      end
      chk("r_beats", 32'(beat), 32'(len) + 32'd1);
      tick();
      s.rready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      s.arvalid = 1'b0; s.araddr = '0; s.arlen = '0; s.arsize = '0; s.arburst = '0;
      s.awvalid = 1'b0; s.awaddr = '0; s.awlen = '0; s.awsize = '0; s.awburst = '0;
      s.wvalid = 1'b0; s.wdata = '0; s.wstrb = '0; s.wlast = 1'b0;
      s.rready = 1'b1; s.bready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 32'(s.arready), 32'd0);
      chk("rst_awready", 32'(s.awready), 32'd0);
      chk("rst_rvalid",  32'(s.rvalid),  32'd0);
      chk("rst_rlast",   32'(s.rlast),   32'd0);
      chk("rst_rdata",   s.rdata,        32'd0);
      chk("rst_rresp",   32'(s.rresp),   32'd0);
      chk("rst_wready",  32'(s.wready),  32'd0);
      chk("rst_bvalid",  32'(s.bvalid),  32'd0);
      chk("rst_bresp",   32'(s.bresp),   32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("arready_after_rst", 32'(s.arready), 32'd1);
      chk("awready_after_rst", 32'(s.awready), 32'd1);
      tick();

      // single-beat write then read
      axi_write(32'h10, 8'd0, 3'd2, INCR, 4'hF, 32'hDEADBEEF, 0, 0, 0, OKAY);
      push_r(32'hDEADBEEF, OKAY, 1'b1);
      axi_read(32'h10, 8'd0, 3'd2, INCR, -1, 32'h0);

      // INCR burst write and readback
      axi_write(32'h100, 8'd3, 3'd2, INCR, 4'hF, 32'd1, 32'd2, 32'd3, 32'd4, OKAY);
      push_r(32'd1, OKAY, 1'b0); push_r(32'd2, OKAY, 1'b0);
      push_r(32'd3, OKAY, 1'b0); push_r(32'd4, OKAY, 1'b1);
      axi_read(32'h100, 8'd3, 3'd2, INCR, -1, 32'h0);

      // WRAP: beat order 0x38, 0x3C, 0x30, 0x34
      axi_write(32'h30, 8'd3, 3'd2, INCR, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, OKAY);
      push_r(32'hA2, OKAY, 1'b0); push_r(32'hA3, OKAY, 1'b0);
      push_r(32'hA0, OKAY, 1'b0); push_r(32'hA1, OKAY, 1'b1);
      axi_read(32'h38, 8'd3, 3'd2, WRAP, -1, 32'h0);
      axi_write(32'h38, 8'd3, 3'd2, WRAP, 4'hF, 32'hB0, 32'hB1, 32'hB2, 32'hB3, OKAY);
      push_r(32'hB2, OKAY, 1'b0); push_r(32'hB3, OKAY, 1'b0);
      push_r(32'hB0, OKAY, 1'b0); push_r(32'hB1, OKAY, 1'b1);
      axi_read(32'h30, 8'd3, 3'd2, INCR, -1, 32'h0);

      // byte strobes, then rready held low before beat 2
      axi_write(32'h200, 8'd3, 3'd2, INCR, 4'hF, 32'hAABBCCDD, 32'h55, 32'h66, 32'h77, OKAY);
      axi_write(32'h200, 8'd0, 3'd2, INCR, 4'b0101, 32'h11223344, 0, 0, 0, OKAY);
      push_r(32'hAA22CC44, OKAY, 1'b0); push_r(32'h55, OKAY, 1'b0);
      push_r(32'h66, OKAY, 1'b0);       push_r(32'h77, OKAY, 1'b1);
      axi_read(32'h200, 8'd3, 3'd2, INCR, 2, 32'h66);

      // error responses
      push_r(32'h0, DECERR, 1'b1);
      axi_read(32'h4000, 8'd0, 3'd2, INCR, -1, 32'h0);
      push_r(32'h0, SLVERR, 1'b1);
      axi_read(32'h10, 8'd0, 3'd3, INCR, -1, 32'h0);
      axi_write(32'h100, 8'd1, 3'd2, 2'b11, 4'hF, 32'hFFFFFFFF, 32'hEEEEEEEE, 0, 0, SLVERR);
      push_r(32'd1, OKAY, 1'b0); push_r(32'd2, OKAY, 1'b1);
      axi_read(32'h100, 8'd1, 3'd2, INCR, -1, 32'h0);

      // simultaneous AR and AW: read first, write after
      s.awaddr = 32'h100; s.awlen = 8'd0; s.awsize = 3'd2; s.awburst = INCR; s.awvalid = 1'b1;
      s.araddr = 32'h100; s.arlen = 8'd0; s.arsize = 3'd2; s.arburst = INCR; s.arvalid = 1'b1;
      push_r(32'd1, OKAY, 1'b1);
      @(negedge clk);
      chk("arb_arready", 32'(s.arready), 32'd1);
      chk("arb_awready", 32'(s.awready), 32'd0);
      tick();
      s.arvalid = 1'b0;
      @(negedge clk);
      chk("arb_awready_busy", 32'(s.awready), 32'd0);
      axi_write(32'h100, 8'd0, 3'd2, INCR, 4'hF, 32'h99, 0, 0, 0, OKAY);
      push_r(32'h99, OKAY, 1'b1);
      axi_read(32'h100, 8'd0, 3'd2, INCR, -1, 32'h0);

      // reset during beat 2 of a 4-beat write
      axi_write(32'h308, 8'd0, 3'd2, INCR, 4'hF, 32'h5A, 0, 0, 0, OKAY);
      aw_hs(32'h300, 8'd3, 3'd2, INCR);
      w_beat(32'hC0, 4'hF, 1'b0);
      w_beat(32'hC1, 4'hF, 1'b0);
      s.wdata = 32'hC2; s.wstrb = 4'hF; s.wlast = 1'b0; s.wvalid = 1'b1;
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_rst_arready", 32'(s.arready), 32'd0);
      chk("mid_rst_wready",  32'(s.wready),  32'd0);
      chk("mid_rst_bvalid",  32'(s.bvalid),  32'd0);
      chk("mid_rst_rvalid",  32'(s.rvalid),  32'd0);
      chk("mid_rst_rdata",   s.rdata,        32'd0);
      chk("mid_rst_bresp",   32'(s.bresp),   32'd0);
      tick();
      s.wvalid = 1'b0;
      rst_n = 1'b1;
      tick();
      push_r(32'hC0, OKAY, 1'b0); push_r(32'hC1, OKAY, 1'b0); push_r(32'h5A, OKAY, 1'b1);
      axi_read(32'h300, 8'd2, 3'd2, INCR, -1, 32'h0);

      repeat (3) tick();
      chk("r_queue_drained", 32'(rq.size()), 32'd0);
      chk("b_queue_drained", 32'(bq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
